pifo_dequeue_scheduler: RTL and testbench

Packet-level dequeue scheduler for the NetFPGA-SUME PIFO scheduling path. Arbitrates among PORT_NUM per-queue AXI4-Stream heads by PIFO rank, with the smallest rank served first. Locks the grant for a whole packet and muxes the winner onto one output AXI4-Stream toward the output port logic. Sits downstream of the enqueue agent and its per-queue buffers.

---
 rtl/pifo_sched_pkg.sv | 22 ++
 rtl/pifo_dequeue_scheduler_if.sv | 46 ++++
 rtl/pifo_rank_min_select.sv | 30 +++
 rtl/pifo_dequeue_scheduler.sv | 138 +++++++++++++
 tb/tb_pifo_dequeue_scheduler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pifo_sched_pkg.sv
// Shared types and constants for the PIFO dequeue scheduling path.
// Holds the FSM encodings, the rank type and the one-hot decode helper.
package pifo_sched_pkg;

   localparam int unsigned RANK_W_DEFAULT = 16;

   typedef logic [RANK_W_DEFAULT-1:0] rank_t;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   // Returns the index of the highest set bit; callers only pass one-hot or zero.
   function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (onehot[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/pifo_dequeue_scheduler_if.sv
// Bundle of per-queue AXI4-Stream heads, ranks, the muxed output stream and status.
// The scheduler uses the slave modport; the surrounding queue/port logic uses master.
interface pifo_dequeue_scheduler_if
   import pifo_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 256,
   parameter int unsigned SUME_META_WIDTH = 128,
   parameter int unsigned PORT_NUM        = 5,
   parameter int unsigned RANK_WIDTH      = RANK_W_DEFAULT
);

   logic [PORT_NUM*DATA_WIDTH-1:0]      s_axis_tdata;
   logic [PORT_NUM*DATA_WIDTH/8-1:0]    s_axis_tkeep;
   logic [PORT_NUM*SUME_META_WIDTH-1:0] s_axis_tuser;
   logic [PORT_NUM-1:0]                 s_axis_tvalid;
   logic [PORT_NUM-1:0]                 s_axis_tlast;
   logic [PORT_NUM-1:0]                 s_axis_tready;
   logic [PORT_NUM*RANK_WIDTH-1:0]      s_rank;

   logic [DATA_WIDTH-1:0]               m_axis_tdata;
   logic [DATA_WIDTH/8-1:0]             m_axis_tkeep;
   logic [SUME_META_WIDTH-1:0]          m_axis_tuser;
   logic                                m_axis_tvalid;
   logic                                m_axis_tlast;
   logic                                m_axis_tready;

   logic [PORT_NUM-1:0]                 grant;
   logic                                busy;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast, s_rank,
      output m_axis_tready,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
      input  grant, busy
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast, s_rank,
      input  m_axis_tready,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
      output grant, busy
   );

endinterface

// File: rtl/pifo_rank_min_select.sv
// Combinational minimum-rank picker over a valid vector; ties go to the lowest index.
// Ranks compare unsigned across the full width.
module pifo_rank_min_select #(
   parameter int unsigned PORT_NUM   = 5,
   parameter int unsigned RANK_WIDTH = 16,
   parameter int unsigned IDX_WIDTH  = 3
) (
   input  logic [PORT_NUM-1:0]            valid,
   input  logic [PORT_NUM*RANK_WIDTH-1:0] ranks,
   output logic [IDX_WIDTH-1:0]           idx,
   output logic                           found
);

   logic [RANK_WIDTH-1:0] best;

   // Strict less-than keeps the earlier (lower) index on equal ranks.
   always_comb begin
      best  = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(PORT_NUM); i++) begin
         if (valid[i] && (!found || ranks[i*RANK_WIDTH +: RANK_WIDTH] < best)) begin
            best  = ranks[i*RANK_WIDTH +: RANK_WIDTH];
            idx   = IDX_WIDTH'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pifo_dequeue_scheduler.sv
// Packet-level PIFO dequeue scheduler: smallest rank wins, grant held for a whole packet.
// Optional starvation guard enabled by defining PIFO_STARVATION_GUARD_EN.
module pifo_dequeue_scheduler
   import pifo_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 256,
   parameter int unsigned SUME_META_WIDTH = 128,
   parameter int unsigned PORT_NUM        = 5,
   parameter int unsigned RANK_WIDTH      = RANK_W_DEFAULT,
   parameter int unsigned AGE_WIDTH       = 4,
   parameter int unsigned AGE_LIMIT       = 8
) (
   input logic                     clk,
   input logic                     reset,
   pifo_dequeue_scheduler_if.slave bus
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned IDX_W      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   logic [0:0]          state_q, state_d;
   logic [PORT_NUM-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]    sel_idx, win_idx, g_idx;
   logic                any_valid;

   logic [DATA_WIDTH-1:0]      m_tdata;
   logic [KEEP_WIDTH-1:0]      m_tkeep;
   logic [SUME_META_WIDTH-1:0] m_tuser;
   logic                       m_tvalid, m_tlast;

   pifo_rank_min_select #(
      .PORT_NUM   (PORT_NUM),
      .RANK_WIDTH (RANK_WIDTH),
      .IDX_WIDTH  (IDX_W)
   ) u_rank_min (
      .valid (bus.s_axis_tvalid),
      .ranks (bus.s_rank),
      .idx   (sel_idx),
      .found (any_valid)
   );

`ifdef PIFO_STARVATION_GUARD_EN
   logic [AGE_WIDTH-1:0] age_q [PORT_NUM];
   logic                 starved_any;
   logic [IDX_W-1:0]     starved_idx;

   // Walk downwards so the lowest starved index is the one left standing.
   always_comb begin
      starved_any = 1'b0;
      starved_idx = '0;
      for (int i = int'(PORT_NUM) - 1; i >= 0; i--) begin
         if (bus.s_axis_tvalid[i] && (32'(age_q[i]) >= AGE_LIMIT)) begin
            starved_any = 1'b1;
            starved_idx = IDX_W'(i);
         end
      end
   end

   assign win_idx = starved_any ? starved_idx : sel_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(PORT_NUM); i++) age_q[i] <= '0;
      end else if (state_q == ST_IDLE && any_valid) begin
         for (int i = 0; i < int'(PORT_NUM); i++) begin
            if (win_idx == IDX_W'(i)) begin
               age_q[i] <= '0;
            end else if (bus.s_axis_tvalid[i] && age_q[i] != '1) begin
               age_q[i] <= age_q[i] + 1'b1;
            end
         end
      end
   end
`else
   assign win_idx = sel_idx;
`endif

   assign g_idx = IDX_W'(onehot_to_idx(32'(grant_q)));

   // Pass-through of the granted head; everything reads zero while nothing is granted.
   always_comb begin
      m_tdata  = '0;
      m_tkeep  = '0;
      m_tuser  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      if (grant_q != '0) begin
         m_tdata  = bus.s_axis_tdata[g_idx*DATA_WIDTH +: DATA_WIDTH];
         m_tkeep  = bus.s_axis_tkeep[g_idx*KEEP_WIDTH +: KEEP_WIDTH];
         m_tuser  = bus.s_axis_tuser[g_idx*SUME_META_WIDTH +: SUME_META_WIDTH];
         m_tvalid = bus.s_axis_tvalid[g_idx];
         m_tlast  = bus.s_axis_tlast[g_idx];
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               state_d = ST_STREAM;
               grant_d = PORT_NUM'(1) << win_idx;
            end
         end
         ST_STREAM: begin
            if (m_tvalid && bus.m_axis_tready && m_tlast) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   assign bus.m_axis_tdata  = m_tdata;
   assign bus.m_axis_tkeep  = m_tkeep;
   assign bus.m_axis_tuser  = m_tuser;
   assign bus.m_axis_tvalid = m_tvalid;
   assign bus.m_axis_tlast  = m_tlast;
   assign bus.s_axis_tready = grant_q & {PORT_NUM{bus.m_axis_tready}};
   assign bus.grant         = grant_q;
   assign bus.busy          = (state_q == ST_STREAM);

endmodule

// File: tb/tb_pifo_dequeue_scheduler.sv
// Directed self-checking bench for pifo_dequeue_scheduler.
// Starvation scenario expectations follow PIFO_STARVATION_GUARD_EN.
module tb_pifo_dequeue_scheduler;
   import pifo_sched_pkg::*;

   localparam int DW = 256;
   localparam int KW = DW / 8;
   localparam int MW = 128;
   localparam int PN = 5;
   localparam int RW = 16;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pifo_dequeue_scheduler_if bus ();

   pifo_dequeue_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [DW-1:0] dat(input int q, input int b);
      return {8'(q), 232'h0, 8'hA5, 8'(b)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_q(input int q, input logic v, input int b, input logic l,
                        input logic [RW-1:0] r);
      bus.s_axis_tvalid[q]        = v;
      bus.s_axis_tdata[q*DW +: DW] = dat(q, b);
      bus.s_axis_tkeep[q*KW +: KW] = '1;
      bus.s_axis_tuser[q*MW +: MW] = MW'(q + 1);
      bus.s_axis_tlast[q]         = l;
      bus.s_rank[q*RW +: RW]       = r;
   endtask

   task automatic clear_inputs();
      bus.s_axis_tdata  = '0;
      bus.s_axis_tkeep  = '0;
      bus.s_axis_tuser  = '0;
      bus.s_axis_tvalid = '0;
      bus.s_axis_tlast  = '0;
      bus.s_rank        = '0;
      bus.m_axis_tready = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.grant !== 5'b0) begin errors++; $display("FAIL reset_grant got=%b exp=%b", bus.grant, 5'b0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if ({bus.m_axis_tvalid, bus.m_axis_tlast} !== 2'b00) begin errors++; $display("FAIL reset_mvalid_last got=%b exp=00", {bus.m_axis_tvalid, bus.m_axis_tlast}); end
      checks++; if (bus.s_axis_tready !== 5'b0) begin errors++; $display("FAIL reset_sready got=%b exp=00000", bus.s_axis_tready); end
      checks++; if (bus.m_axis_tdata !== '0) begin errors++; $display("FAIL reset_mdata got=%h exp=0", bus.m_axis_tdata); end
   endtask

   task automatic test_single_queue();
      clear_inputs();
      set_q(2, 1'b1, 0, 1'b0, 16'd5);
      #1;
      checks++; if (bus.grant !== 5'b0) begin errors++; $display("FAIL single_pre_grant got=%b exp=00000", bus.grant); end
      checks++; if ({bus.m_axis_tvalid, bus.m_axis_tdata} !== '0) begin errors++; $display("FAIL single_ungranted_out got=%b/%h exp=0/0", bus.m_axis_tvalid, bus.m_axis_tdata); end
      step();
      checks++; if (bus.grant !== 5'b00100) begin errors++; $display("FAIL single_grant got=%b exp=00100", bus.grant); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
      checks++; if (bus.m_axis_tdata !== dat(2, 0)) begin errors++; $display("FAIL single_beat0 got=%h exp=%h", bus.m_axis_tdata, dat(2, 0)); end
      checks++; if (bus.m_axis_tuser !== MW'(3)) begin errors++; $display("FAIL single_tuser got=%h exp=3", bus.m_axis_tuser); end
      checks++; if (bus.s_axis_tready !== 5'b00100) begin errors++; $display("FAIL single_sready got=%b exp=00100", bus.s_axis_tready); end
      step();
      set_q(2, 1'b1, 1, 1'b0, 16'd5);
      #1;
      checks++; if ({bus.m_axis_tdata, bus.m_axis_tlast} !== {dat(2, 1), 1'b0}) begin errors++; $display("FAIL single_beat1 got=%h/%b exp=%h/0", bus.m_axis_tdata, bus.m_axis_tlast, dat(2, 1)); end
      step();
      set_q(2, 1'b1, 2, 1'b1, 16'd5);
      #1;
      checks++; if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast} !== {1'b1, dat(2, 2), 1'b1}) begin errors++; $display("FAIL single_beat2 got=%b/%h/%b exp=1/%h/1", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, dat(2, 2)); end
      step();
      clear_inputs();
      #1;
      checks++; if ({bus.grant, bus.busy, bus.m_axis_tvalid} !== 7'b0) begin errors++; $display("FAIL single_idle_after got=%b/%b/%b exp=00000/0/0", bus.grant, bus.busy, bus.m_axis_tvalid); end
   endtask

   task automatic test_rank_order();
      clear_inputs();
      set_q(0, 1'b1, 0, 1'b1, 16'd40);
      set_q(1, 1'b1, 0, 1'b1, 16'd7);
      set_q(3, 1'b1, 0, 1'b1, 16'd7);
      step();
      checks++; if (bus.grant !== 5'b00010) begin errors++; $display("FAIL order_first got=%b exp=00010", bus.grant); end
      checks++; if (bus.m_axis_tdata !== dat(1, 0)) begin errors++; $display("FAIL order_first_data got=%h exp=%h", bus.m_axis_tdata, dat(1, 0)); end
      step();
      set_q(1, 1'b0, 0, 1'b0, 16'd7);
      #1;
      checks++; if (bus.grant !== 5'b0) begin errors++; $display("FAIL order_bubble got=%b exp=00000", bus.grant); end
      step();
      checks++; if (bus.grant !== 5'b01000) begin errors++; $display("FAIL order_second got=%b exp=01000", bus.grant); end
      step();
      set_q(3, 1'b0, 0, 1'b0, 16'd7);
      step();
      checks++; if (bus.grant !== 5'b00001) begin errors++; $display("FAIL order_third got=%b exp=00001", bus.grant); end
      step();
      clear_inputs();
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL order_done_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_unsigned_and_tie();
      clear_inputs();
      set_q(0, 1'b1, 0, 1'b1, 16'h8000);
      set_q(1, 1'b1, 0, 1'b1, 16'h7fff);
      step();
      checks++; if (bus.grant !== 5'b00010) begin errors++; $display("FAIL unsigned_rank got=%b exp=00010", bus.grant); end
      step();
      clear_inputs();
      for (int q = 0; q < PN; q++) set_q(q, 1'b1, 0, 1'b1, 16'd9);
      step();
      checks++; if (bus.grant !== 5'b00001) begin errors++; $display("FAIL tie_all got=%b exp=00001", bus.grant); end
      step();
      set_q(0, 1'b0, 0, 1'b0, 16'd9);
      step();
      checks++; if (bus.grant !== 5'b00010) begin errors++; $display("FAIL tie_next got=%b exp=00010", bus.grant); end
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_backpressure();
      clear_inputs();
      set_q(1, 1'b1, 0, 1'b0, 16'd3);
      step();
      step();
      set_q(1, 1'b1, 1, 1'b0, 16'd3);
      bus.m_axis_tready = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++; if ({bus.m_axis_tvalid, bus.m_axis_tdata} !== {1'b1, dat(1, 1)}) begin errors++; $display("FAIL bp_hold_data[%0d] got=%b/%h exp=1/%h", k, bus.m_axis_tvalid, bus.m_axis_tdata, dat(1, 1)); end
         checks++; if ({bus.s_axis_tready, bus.grant} !== {5'b00000, 5'b00010}) begin errors++; $display("FAIL bp_hold_ctrl[%0d] got=%b/%b exp=00000/00010", k, bus.s_axis_tready, bus.grant); end
         step();
      end
      bus.m_axis_tready = 1'b1;
      #1;
      checks++; if ({bus.s_axis_tready, bus.m_axis_tdata} !== {5'b00010, dat(1, 1)}) begin errors++; $display("FAIL bp_resume got=%b/%h exp=00010/%h", bus.s_axis_tready, bus.m_axis_tdata, dat(1, 1)); end
      step();
      set_q(1, 1'b1, 2, 1'b1, 16'd3);
      #1;
      checks++; if ({bus.m_axis_tdata, bus.m_axis_tlast} !== {dat(1, 2), 1'b1}) begin errors++; $display("FAIL bp_last got=%h/%b exp=%h/1", bus.m_axis_tdata, bus.m_axis_tlast, dat(1, 2)); end
      step();
      clear_inputs();
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_done_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_isolation();
      clear_inputs();
      set_q(0, 1'b1, 0, 1'b0, 16'd10);
      step();
      set_q(4, 1'b1, 0, 1'b1, 16'd0);
      #1;
      for (int b = 0; b < 3; b++) begin
         checks++; if ({bus.s_axis_tready[4], bus.grant} !== {1'b0, 5'b00001}) begin errors++; $display("FAIL iso_hold[%0d] got=%b/%b exp=0/00001", b, bus.s_axis_tready[4], bus.grant); end
         checks++; if (bus.m_axis_tdata !== dat(0, b)) begin errors++; $display("FAIL iso_data[%0d] got=%h exp=%h", b, bus.m_axis_tdata, dat(0, b)); end
         step();
         if (b < 2) set_q(0, 1'b1, b + 1, (b + 1 == 2), 16'd10);
         else set_q(0, 1'b0, 0, 1'b0, 16'd10);
         #1;
      end
      checks++; if (bus.grant !== 5'b0) begin errors++; $display("FAIL iso_bubble got=%b exp=00000", bus.grant); end
      step();
      checks++; if ({bus.grant, bus.m_axis_tdata} !== {5'b10000, dat(4, 0)}) begin errors++; $display("FAIL iso_q4_grant got=%b/%h exp=10000/%h", bus.grant, bus.m_axis_tdata, dat(4, 0)); end
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_drop_valid();
      clear_inputs();
      set_q(3, 1'b1, 0, 1'b0, 16'd2);
      step();
      step();
      set_q(3, 1'b0, 1, 1'b0, 16'd2);
      #1;
      checks++; if ({bus.m_axis_tvalid, bus.grant, bus.busy} !== {1'b0, 5'b01000, 1'b1}) begin errors++; $display("FAIL drop_gap got=%b/%b/%b exp=0/01000/1", bus.m_axis_tvalid, bus.grant, bus.busy); end
      step();
      checks++; if (bus.grant !== 5'b01000) begin errors++; $display("FAIL drop_keep got=%b exp=01000", bus.grant); end
      set_q(3, 1'b1, 1, 1'b1, 16'd2);
      #1;
      checks++; if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata} !== {2'b11, dat(3, 1)}) begin errors++; $display("FAIL drop_resume got=%b/%b/%h exp=1/1/%h", bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, dat(3, 1)); end
      step();
      clear_inputs();
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_done_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_reset_mid_packet();
      clear_inputs();
      set_q(2, 1'b1, 0, 1'b0, 16'd4);
      step();
      step();
      set_q(2, 1'b1, 1, 1'b0, 16'd4);
      #1;
      checks++; if ({bus.busy, bus.m_axis_tdata} !== {1'b1, dat(2, 1)}) begin errors++; $display("FAIL rstmid_pre got=%b/%h exp=1/%h", bus.busy, bus.m_axis_tdata, dat(2, 1)); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if ({bus.grant, bus.busy, bus.m_axis_tvalid} !== 7'b0) begin errors++; $display("FAIL rstmid_state got=%b/%b/%b exp=00000/0/0", bus.grant, bus.busy, bus.m_axis_tvalid); end
      checks++; if (bus.s_axis_tready !== 5'b0) begin errors++; $display("FAIL rstmid_sready got=%b exp=00000", bus.s_axis_tready); end
      clear_inputs();
      step();
   endtask

   task automatic test_starvation();
      do_reset();
      set_q(0, 1'b1, 0, 1'b1, 16'd1);
      set_q(4, 1'b1, 0, 1'b1, 16'd100);
`ifdef PIFO_STARVATION_GUARD_EN
      for (int d = 1; d <= 8; d++) begin
         step();
         checks++; if (bus.grant !== 5'b00001) begin errors++; $display("FAIL starve_dec%0d got=%b exp=00001", d, bus.grant); end
         step();
      end
      step();
      checks++; if (bus.grant !== 5'b10000) begin errors++; $display("FAIL starve_dec9 got=%b exp=10000", bus.grant); end
      step();
      step();
      checks++; if (bus.grant !== 5'b00001) begin errors++; $display("FAIL starve_dec10 got=%b exp=00001", bus.grant); end
      step();
      // With q4's age cleared it must again lose to q0 at the next decision.
      step();
      checks++; if (bus.grant !== 5'b00001) begin errors++; $display("FAIL starve_dec11 got=%b exp=00001", bus.grant); end
      step();
`else
      for (int d = 1; d <= 9; d++) begin
         step();
         checks++; if (bus.grant !== 5'b00001) begin errors++; $display("FAIL rank_only_dec%0d got=%b exp=00001", d, bus.grant); end
         step();
      end
`endif
      clear_inputs();
      step();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single_queue();
      test_rank_order();
      test_unsigned_and_tie();
      test_backpressure();
      test_isolation();
      test_drop_valid();
      test_reset_mid_packet();
      test_starvation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
